cycle_sequencer: RTL and testbench
==================================

// Module: cycle_sequencer
// PURPOSE
// Multi-cycle instruction sequencer for the 8-bit CPU. Steps each instruction through
// FETCH/DECODE/EXECUTE and, where needed, waits on data memory or on the IN/OUT handshakes.
// Produces the single-cycle COMMIT strobe that qualifies every write enable produced by the
// decode Control block (REG_W_EN, DMEM_W_EN, FLAG_W, PC_LD_EN), plus the PC advance strobe.
// Also handles the halt, resume and single-step debug states.
// PARAMETERS
// IMEM_WAIT  0   extra cycles held in FETCH before IR_LD (instruction memory latency)
// DMEM_WAIT  1   cycles held in MEM before commit (data memory latency, 1..15)
// CNT_W      16  width of the retired-instruction counter
// PORTS
// CLK        in   1      system clock, rising edge
// RST        in   1      asynchronous reset, active-high
// HALT_OP    in   1      decoded I_END
// IN_OP      in   1      decoded IN
// OUT_OP     in   1      decoded OUT
// DMEM_OP    in   1      decoded LDM/LDD/LDI/LDX/STO/STI/STX/SWAP, or any ALU op with a memory operand
// IN_VALID   in   1      external input byte valid
// OUT_READY  in   1      external sink ready
// RESUME     in   1      leave HALTED (level, sampled per cycle)
// STEP_MODE  in   1      1 = pause after every retired instruction
// STEP       in   1      release one instruction while paused
// IR_LD      out  1      load the instruction register
// COMMIT     out  1      qualifies all architectural writes
// PC_ADV     out  1      PC update strobe (increment, or load if PC_LD_EN)
// IN_ACK     out  1      input byte consumed
// OUT_VALID  out  1      output byte presented
// HALTED     out  1      core is in HALTED
// PAUSED     out  1      core is in PAUSE
// STATE      out  3      current state encoding, for debug
// INSTR_CNT  out  CNT_W  instructions retired, wraps to 0
// BEHAVIOUR
// - Reset (async, RST=1): state=FETCH, wait counter=0, INSTR_CNT=0, all 1-bit outputs 0.
// - State encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, IO_IN=4, IO_OUT=5, HALTED=6, PAUSE=7.
// - FETCH: count IMEM_WAIT cycles, then pulse IR_LD for 1 cycle and go to DECODE.
//   With IMEM_WAIT=0, IR_LD is asserted on the first FETCH cycle.
// - DECODE: 1 cycle, no strobes. Next state by priority:
//   HALT_OP -> HALTED; IN_OP -> IO_IN; OUT_OP -> IO_OUT; DMEM_OP -> MEM; otherwise EXEC.
// - EXEC: COMMIT=PC_ADV=1 for exactly 1 cycle.
// - MEM: hold DMEM_WAIT cycles; COMMIT=PC_ADV=1 on the last cycle only.
// - IO_IN: wait for IN_VALID. In the cycle IN_VALID=1: IN_ACK=COMMIT=PC_ADV=1, then exit.
// - IO_OUT: OUT_VALID=1 while in the state. In the cycle OUT_READY=1: COMMIT=PC_ADV=1, then
//   exit; OUT_VALID drops the next cycle.
// - Exit after any commit: go to PAUSE if STEP_MODE=1, otherwise FETCH.
// - INSTR_CNT increments by 1 on every COMMIT cycle and wraps at 2^CNT_W-1 -> 0.
// - HALTED: HALTED=1, no strobes, INSTR_CNT frozen.
//   RESUME=1 -> one PC_ADV pulse (no COMMIT, no count), then FETCH.
// - PAUSE: PAUSED=1. STEP=1 -> FETCH. STEP_MODE=0 -> FETCH. STEP has priority.
// - The 3-cycle minimum instruction (FETCH, DECODE, EXEC) applies only when IMEM_WAIT=0.
// - COMMIT, PC_ADV, IR_LD and IN_ACK are never asserted in the same cycle as one another,
//   except COMMIT+PC_ADV, and IN_ACK+COMMIT+PC_ADV.
// - Reset mid-wait: any state returns to FETCH with no strobe emitted; a partial IN/OUT
//   handshake is abandoned and OUT_VALID drops asynchronously.
// - Decode inputs are sampled only in DECODE; changes in other states are ignored.
// TESTING
// - EXEC op, IMEM_WAIT=0: IR_LD in cycle 0, COMMIT+PC_ADV in cycle 2, INSTR_CNT 0->1.
// - DMEM_OP, DMEM_WAIT=3: MEM held 3 cycles, COMMIT on the 3rd only; instruction takes 5 cycles.
// - IN_OP with IN_VALID rising 4 cycles after DECODE: IN_ACK+COMMIT asserted together exactly
//   once, then FETCH.
// - OUT_OP with OUT_READY held low 10 cycles: OUT_VALID=1 throughout, COMMIT=0;
//   OUT_READY=1 -> single COMMIT.
// - HALT_OP: HALTED=1, no COMMIT for 20 cycles, INSTR_CNT unchanged;
//   RESUME -> one PC_ADV, then FETCH.
// - STEP_MODE=1 over 3 instructions with STEP pulses: exactly 3 COMMITs, PAUSED between them;
//   RST asserted in MEM -> STATE=0 immediately, no COMMIT.

Source files
------------

// File: rtl/cycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module : cycle_sequencer
// Brief  : multi-cycle instruction sequencer with memory/IO waits and halt/step debug
// Rev    : 1.0
// ============================================================================
module cycle_sequencer #(
  parameter int IMEM_WAIT = 0,
  parameter int DMEM_WAIT = 1,
  parameter int CNT_W     = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_halt_op,
  input  logic             i_in_op,
  input  logic             i_out_op,
  input  logic             i_dmem_op,
  input  logic             i_in_valid,
  input  logic             i_out_ready,
  input  logic             i_resume,
  input  logic             i_step_mode,
  input  logic             i_step,
  output logic             o_ir_ld,
  output logic             o_commit,
  output logic             o_pc_adv,
  output logic             o_in_ack,
  output logic             o_out_valid,
  output logic             o_halted,
  output logic             o_paused,
  output logic [2:0]       o_state,
  output logic [CNT_W-1:0] o_instr_cnt
);

  localparam int                WAIT_W      = 8;
  localparam logic [WAIT_W-1:0] c_imem_last = WAIT_W'(IMEM_WAIT);
  localparam logic [WAIT_W-1:0] c_dmem_last = WAIT_W'(DMEM_WAIT - 1);

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_IO_IN  = 3'd4,
    ST_IO_OUT = 3'd5,
    ST_HALTED = 3'd6,
    ST_PAUSE  = 3'd7
  } state_t;

  state_t            r_state;
  logic [WAIT_W-1:0] r_wait;
  logic [CNT_W-1:0]  r_instr_cnt;

  logic   w_fetch_done;
  logic   w_mem_done;
  logic   w_in_done;
  logic   w_out_done;
  logic   w_commit;
  logic   w_resume;
  state_t w_after_commit;

  assign w_fetch_done   = (r_state == ST_FETCH)  && (r_wait == c_imem_last);
  assign w_mem_done     = (r_state == ST_MEM)    && (r_wait == c_dmem_last);
  assign w_in_done      = (r_state == ST_IO_IN)  && i_in_valid;
  assign w_out_done     = (r_state == ST_IO_OUT) && i_out_ready;
  assign w_commit       = (r_state == ST_EXEC) || w_mem_done || w_in_done || w_out_done;
  assign w_resume       = (r_state == ST_HALTED) && i_resume;
  assign w_after_commit = i_step_mode ? ST_PAUSE : ST_FETCH;

  // Strobes are masked while reset is held so the FETCH state seen during reset emits nothing.
  assign o_ir_ld     = w_fetch_done & ~i_rst;
  assign o_commit    = w_commit & ~i_rst;
  assign o_pc_adv    = (w_commit | w_resume) & ~i_rst;
  assign o_in_ack    = w_in_done & ~i_rst;
  assign o_out_valid = (r_state == ST_IO_OUT) & ~i_rst;
  assign o_halted    = (r_state == ST_HALTED);
  assign o_paused    = (r_state == ST_PAUSE);
  assign o_state     = r_state;
  assign o_instr_cnt = r_instr_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_FETCH;
      r_wait      <= '0;
      r_instr_cnt <= '0;
    end else begin
      if (w_commit) begin
        r_instr_cnt <= r_instr_cnt + CNT_W'(1);
      end
      case (r_state)
        ST_FETCH: begin
          if (w_fetch_done) begin
            r_wait  <= '0;
            r_state <= ST_DECODE;
          end else begin
            r_wait <= r_wait + WAIT_W'(1);
          end
        end
        ST_DECODE: begin
          r_wait <= '0;
          if (i_halt_op)      r_state <= ST_HALTED;
          else if (i_in_op)   r_state <= ST_IO_IN;
          else if (i_out_op)  r_state <= ST_IO_OUT;
          else if (i_dmem_op) r_state <= ST_MEM;
          else                r_state <= ST_EXEC;
        end
        ST_EXEC: r_state <= w_after_commit;
        ST_MEM: begin
          if (w_mem_done) begin
            r_wait  <= '0;
            r_state <= w_after_commit;
          end else begin
            r_wait <= r_wait + WAIT_W'(1);
          end
        end
        ST_IO_IN:  if (w_in_done)  r_state <= w_after_commit;
        ST_IO_OUT: if (w_out_done) r_state <= w_after_commit;
        ST_HALTED: if (i_resume)   r_state <= ST_FETCH;
        ST_PAUSE:  if (i_step || !i_step_mode) r_state <= ST_FETCH;
        default:   r_state <= ST_FETCH;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cycle_sequencer.sv
`default_nettype none
// Bench for cycle_sequencer: per-cycle reference model plus directed scenario checks.
module tb_cycle_sequencer;
  localparam int IMEM_WAIT = 0;
  localparam int DMEM_WAIT = 3;
  localparam int CNT_W     = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic halt_op = 0, in_op = 0, out_op = 0, dmem_op = 0;
  logic in_valid = 0, out_ready = 0, resume = 0, step_mode = 0, step = 0;
  logic ir_ld, commit, pc_adv, in_ack, out_valid, halted, paused;
  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;

  int checks = 0, errors = 0;
  int n_commit = 0, n_in_ack = 0;
  int c0, a0, k;

  // reference model: spec state number, cycles spent in it, retired count
  int m_state = 0, m_dwell = 0, m_cnt = 0;
  int rst_edges = 0, m_rst_edges = 0;
  logic e_ir_ld, e_commit, e_pc_adv, e_in_ack, e_out_valid, e_halted, e_paused;
  logic [12:0] exp_v, act_v;

  always #5 clk = ~clk;

  cycle_sequencer #(
    .IMEM_WAIT(IMEM_WAIT),
    .DMEM_WAIT(DMEM_WAIT),
    .CNT_W    (CNT_W)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_halt_op  (halt_op),
    .i_in_op    (in_op),
    .i_out_op   (out_op),
    .i_dmem_op  (dmem_op),
    .i_in_valid (in_valid),
    .i_out_ready(out_ready),
    .i_resume   (resume),
    .i_step_mode(step_mode),
    .i_step     (step),
    .o_ir_ld    (ir_ld),
    .o_commit   (commit),
    .o_pc_adv   (pc_adv),
    .o_in_ack   (in_ack),
    .o_out_valid(out_valid),
    .o_halted   (halted),
    .o_paused   (paused),
    .o_state    (state),
    .o_instr_cnt(cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic void go(input int s);
    m_state = s;
    m_dwell = 0;
  endfunction

  always @(posedge rst) rst_edges++;

  always @(negedge clk) begin
    if (rst || rst_edges != m_rst_edges) begin
      m_rst_edges = rst_edges;
      go(0);
      m_cnt = 0;
    end
    if (rst) begin
      {e_ir_ld, e_commit, e_pc_adv, e_in_ack, e_out_valid, e_halted, e_paused} = '0;
    end else begin
      e_ir_ld     = (m_state == 0) && (m_dwell == IMEM_WAIT);
      e_commit    = (m_state == 2) || ((m_state == 3) && (m_dwell == DMEM_WAIT - 1)) ||
                    ((m_state == 4) && in_valid) || ((m_state == 5) && out_ready);
      e_pc_adv    = e_commit || ((m_state == 6) && resume);
      e_in_ack    = (m_state == 4) && in_valid;
      e_out_valid = (m_state == 5);
      e_halted    = (m_state == 6);
      e_paused    = (m_state == 7);
    end
    exp_v = {e_ir_ld, e_commit, e_pc_adv, e_in_ack, e_out_valid, e_halted, e_paused,
             3'(m_state), CNT_W'(m_cnt)};
    act_v = {ir_ld, commit, pc_adv, in_ack, out_valid, halted, paused, state, cnt};
    chk("cycle_model", 32'(act_v), 32'(exp_v));
    n_commit += int'(commit);
    n_in_ack += int'(in_ack);
    if (!rst) begin
      if (e_commit) m_cnt = (m_cnt + 1) % (1 << CNT_W);
      case (m_state)
        0: if (e_ir_ld) go(1); else m_dwell++;
        1: go(halt_op ? 6 : in_op ? 4 : out_op ? 5 : dmem_op ? 3 : 2);
        2, 3, 4, 5: if (e_commit) go(step_mode ? 7 : 0); else m_dwell++;
        6: if (resume) go(0);
        7: if (step || !step_mode) go(0);
        default: go(0);
      endcase
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_state(input int s, input int budget, input string name);
    int n = 0;
    while (int'(state) != s && n < budget) begin
      nxt();
      look();
      n++;
    end
    chk(name, 32'(state), 32'(s));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    look();
    chk("rst_state", 32'(state), 0);
    chk("rst_cnt", 32'(cnt), 0);
    chk("rst_strobes", 32'({ir_ld, commit, pc_adv, in_ack, out_valid, halted, paused}), 0);
    nxt(); rst = 0;

    // plain EXEC instruction: IR_LD cycle 0, commit cycle 2
    look(); chk("exec_irld", 32'(ir_ld), 1);
    nxt(); look(); chk("exec_decode", 32'(state), 1);
    nxt(); look(); chk("exec_commit", 32'({commit, pc_adv}), 2'b11);
    chk("exec_cnt_before", 32'(cnt), 0);
    nxt(); dmem_op = 1; look();
    chk("exec_cnt_after", 32'(cnt), 1);
    chk("exec_fetch", 32'(state), 0);

    // memory op: three MEM cycles, commit on the last
    nxt();
    for (int i = 0; i < DMEM_WAIT; i++) begin
      nxt(); look();
      chk("mem_state", 32'(state), 3);
      chk("mem_commit_last", 32'(commit), 32'(i == DMEM_WAIT - 1));
    end
    nxt(); dmem_op = 0; in_op = 1; look();
    chk("mem_cnt", 32'(cnt), 2);
    chk("mem_fetch", 32'(state), 0);

    // IN: valid arrives 4 cycles after DECODE
    c0 = n_commit; a0 = n_in_ack;
    nxt();
    for (int i = 1; i <= 4; i++) begin
      nxt(); if (i == 4) in_valid = 1; look();
      chk("in_ack", 32'({in_ack, commit, pc_adv}), (i == 4) ? 3'b111 : 3'b000);
    end
    nxt(); in_valid = 0; in_op = 0; out_op = 1; look();
    chk("in_exit_fetch", 32'(state), 0);
    chk("in_one_commit", 32'(n_commit - c0), 1);
    chk("in_one_ack", 32'(n_in_ack - a0), 1);

    // OUT: sink stalls 10 cycles
    nxt(); k = 0;
    repeat (10) begin
      nxt(); look();
      if (out_valid && !commit) k++;
    end
    chk("out_stall", 32'(k), 10);
    nxt(); out_ready = 1; look();
    chk("out_commit", 32'({out_valid, commit}), 2'b11);
    nxt(); out_ready = 0; out_op = 0; halt_op = 1; look();
    chk("out_valid_drop", 32'(out_valid), 0);
    chk("out_cnt", 32'(cnt), 4);

    // HALT for 20 cycles, then RESUME
    nxt();
    nxt(); look(); chk("halted", 32'(halted), 1);
    c0 = n_commit; k = 0;
    repeat (19) begin
      nxt(); look();
      if (pc_adv) k++;
    end
    chk("halt_no_commit", 32'(n_commit - c0), 0);
    chk("halt_no_pcadv", 32'(k), 0);
    chk("halt_cnt_frozen", 32'(cnt), 4);
    nxt(); halt_op = 0; resume = 1; look();
    chk("resume_pcadv", 32'({pc_adv, commit}), 2'b10);
    nxt(); resume = 0; step_mode = 1; look();
    chk("resume_fetch", 32'(state), 0);
    chk("resume_cnt", 32'(cnt), 4);

    // single-step over three instructions; last release by clearing STEP_MODE
    c0 = n_commit;
    for (int i = 0; i < 3; i++) begin
      wait_state(7, 10, "step_reach_pause");
      chk("step_paused", 32'(paused), 1);
      nxt(); look(); chk("step_hold", 32'(state), 7);
      nxt(); if (i < 2) step = 1; else step_mode = 0; look();
      chk("step_release", 32'(state), 7);
      nxt(); step = 0; look();
      chk("step_fetch", 32'(state), 0);
    end
    chk("step_three_commits", 32'(n_commit - c0), 3);
    chk("step_cnt", 32'(cnt), 7);

    // counter wrap 7 -> 0
    nxt(); nxt(); look(); chk("wrap_commit", 32'(commit), 1);
    nxt(); dmem_op = 1; look(); chk("cnt_wrap", 32'(cnt), 0);

    // reset asserted in the middle of MEM
    c0 = n_commit;
    nxt();
    nxt(); look(); chk("mem2_state", 32'(state), 3);
    #2 rst = 1;
    #1;
    chk("rst_async_state", 32'(state), 0);
    chk("rst_async_strobes", 32'({commit, pc_adv, ir_ld}), 0);
    nxt(); rst = 0; dmem_op = 0; look();
    chk("post_rst_irld", 32'(ir_ld), 1);
    chk("post_rst_cnt", 32'(cnt), 0);
    chk("rst_no_commit", 32'(n_commit - c0), 0);

    // one more plain instruction after reset
    nxt(); nxt(); look(); chk("final_commit", 32'(commit), 1);
    nxt(); look(); chk("final_cnt", 32'(cnt), 1);

    nxt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
